// File: rtl/ps2_host_tx_pkg.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_pkg
// Shared PS/2 definitions for the host transmitter and the keyboard receiver:
//   - ps2_state_e : transmitter FSM state encoding
//   - FRAME_BITS  : device clocks per host-to-device frame
//                   (start, 8 data, parity, stop/ack)
//   - STOP_IDX    : index of the stop bit in the host-driven part of the frame
//   - odd_parity(): parity bit that makes the 9-bit {parity, data} word odd
// ---------------------------------------------------------------------------
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_state_e;

  localparam int FRAME_BITS = 11;

  // The host drives data[7:0], parity and stop (indices 0..9) on the first ten
  // device clock falls; the eleventh fall belongs to the device's ACK.
  localparam logic [3:0] STOP_IDX = 4'(FRAME_BITS - 2);

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ---------------------------------------------------------------------------
// ps2_line_sync
// Brings one asynchronous open-drain PS/2 line into the clk domain and flags
// its falling edges. Shared by the host transmitter and the receiver.
//   clk     : system clock
//   reset   : synchronous, active-high
//   line_i  : raw pin level (asynchronous)
//   level_o : synchronised line level
//   fall_o  : registered one-cycle pulse, one cycle after level_o drops
// SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], line_i};
    hist_d = sync_q[SYNC_STAGES-1];
    fall_d = hist_q & ~sync_q[SYNC_STAGES-1];
  end

  // Lines idle high through the pad pull-ups, so the chain resets to 1 and
  // leaving reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    // NOTE: flops are assigned with <= so every stage samples the value from
    // before the edge; blocking assignments here would collapse the chain.
    if (reset) begin
      sync_q <= '1;
      hist_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      fall_q <= fall_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter: inhibits the clock line, issues
// request-to-send, shifts data/parity/stop on device clock falls and checks
// the device ACK. Shares the open-drain pins with the PS/2 receiver.
//   io_mainClk, reset          : system clock, synchronous active-high reset
//   io_tx_valid/ready/data     : command byte handshake (accepted in IDLE)
//   io_busy                    : transfer in progress, receiver ignores lines
//   io_done / io_error         : one-cycle result pulses (ACK / NACK-timeout)
//   io_ps2Clk_read/writeEnable : clock pin level in, pull-low enable out
//   io_ps2Data_read/writeEnable: data pin level in, pull-low enable out
// INHIBIT_CYCLES must be at least 2.
// ---------------------------------------------------------------------------
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 1200,
  parameter int TIMEOUT_CYCLES = 180000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       io_mainClk,
  input  logic       reset,
  input  logic       io_tx_valid,
  input  logic [7:0] io_tx_data,
  output logic       io_tx_ready,
  output logic       io_busy,
  output logic       io_done,
  output logic       io_error,
  input  logic       io_ps2Clk_read,
  output logic       io_ps2Clk_writeEnable,
  input  logic       io_ps2Data_read,
  output logic       io_ps2Data_writeEnable
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                             : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [9:0]       frame_q, frame_d;   // {stop, parity, data}, shifted out LSB first
  logic             clk_we_q, clk_we_d;
  logic             data_we_q, data_we_d;
  logic             ack_q, ack_d;
  logic             done_p, error_p, abort;

  logic clk_level, clk_fall, data_level, data_fall_unused;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk     (io_mainClk),
    .reset   (reset),
    .line_i  (io_ps2Clk_read),
    .level_o (clk_level),
    .fall_o  (clk_fall)
  );

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
    .clk     (io_mainClk),
    .reset   (reset),
    .line_i  (io_ps2Data_read),
    .level_o (data_level),
    .fall_o  (data_fall_unused)
  );

  wire timed_out = (cnt_q == TO_LIMIT);

  always_comb begin
    // NOTE: every signal written below gets its default first; a branch that
    // forgets one then holds the default instead of inferring a latch.
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_d     = bit_q;
    frame_d   = frame_q;
    clk_we_d  = clk_we_q;
    data_we_d = data_we_q;
    ack_d     = ack_q;
    done_p    = 1'b0;
    error_p   = 1'b0;
    abort     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        clk_we_d  = 1'b0;
        data_we_d = 1'b0;
        if (io_tx_valid) begin
          state_d  = ST_INHIBIT;
          frame_d  = {1'b1, odd_parity(io_tx_data), io_tx_data};
          bit_d    = '0;
          clk_we_d = 1'b1;
        end
      end

      ST_INHIBIT: begin
        // Outputs are registered, so data is requested one cycle early to
        // land exactly in the last inhibit cycle.
        if (cnt_q == INH_LAST) begin
          state_d   = ST_START;
          cnt_d     = '0;
          clk_we_d  = 1'b0;
          data_we_d = 1'b1;
        end else if (cnt_q == INH_PRE) begin
          data_we_d = 1'b1;
        end
      end

      ST_START: begin
        if (clk_fall) begin
          state_d   = ST_SHIFT;
          cnt_d     = '0;
          bit_d     = '0;
          data_we_d = ~frame_q[0];
          frame_d   = frame_q >> 1;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (clk_fall) begin
          cnt_d     = '0;
          bit_d     = bit_q + 4'd1;
          data_we_d = ~frame_q[0];
          frame_d   = frame_q >> 1;
          // The stop bit (a 1) has just released the line.
          if (bit_d == STOP_IDX) state_d = ST_ACK;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end

      ST_ACK: begin
        if (clk_fall) begin
          state_d = ST_WAIT_IDLE;
          cnt_d   = '0;
          ack_d   = ~data_level;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_level && data_level) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_p  = ack_q;
          error_p = ~ack_q;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      clk_we_d  = 1'b0;
      data_we_d = 1'b0;
      error_p   = 1'b1;
    end
  end

  always_ff @(posedge io_mainClk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      clk_we_q  <= 1'b0;
      data_we_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      clk_we_q  <= clk_we_d;
      data_we_q <= data_we_d;
      ack_q     <= ack_d;
    end
  end

  // Result pulses are decoded in the final busy cycle, so io_tx_ready rises
  // in the cycle after the pulse and a new byte can never overlap it.
  assign io_tx_ready            = (state_q == ST_IDLE);
  assign io_busy                = (state_q != ST_IDLE);
  assign io_done                = done_p;
  assign io_error               = error_p;
  assign io_ps2Clk_writeEnable  = clk_we_q;
  assign io_ps2Data_writeEnable = data_we_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Bench for ps2_host_tx: open-drain pin model, a PS/2 keyboard model that
// clocks frames and records the data line, a frame model computed from the
// byte value, and a per-cycle monitor of the handshake and inhibit/RTS timing.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INH  = 1200;
  localparam int TO   = 3000;
  localparam int SYNC = 2;
  localparam int HALF = 20;   // device clock half period in main-clock cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, done, error, clk_we, data_we;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_pin, ps2_data_pin;

  // Open-drain wiring: either side may pull low, pull-ups otherwise.
  assign ps2_clk_pin  = ~(clk_we | dev_clk_low);
  assign ps2_data_pin = ~(data_we | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .io_mainClk             (clk),
    .reset                  (reset),
    .io_tx_valid            (tx_valid),
    .io_tx_data             (tx_data),
    .io_tx_ready            (tx_ready),
    .io_busy                (busy),
    .io_done                (done),
    .io_error               (error),
    .io_ps2Clk_read         (ps2_clk_pin),
    .io_ps2Clk_writeEnable  (clk_we),
    .io_ps2Data_read        (ps2_data_pin),
    .io_ps2Data_writeEnable (data_we)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line levels a device sees: start 0, data LSB first, parity making the
  // count of ones odd, stop released high.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (($countones(b) % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // ---------------- per-cycle monitor ----------------
  int cyc = -1;          // cycles since acceptance, -1 when not tracking
  int ncyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int last_done = -100;
  int last_acc = -100;

  always @(negedge clk) begin
    ncyc++;
    if (cyc >= 0) cyc++;
    if (reset) cyc = -1;
    if (cyc >= 1 && cyc <= INH) begin
      check("inhibit_clk_we", clk_we, 1);
      check("inhibit_data_we", data_we, (cyc == INH));
    end else if (cyc == INH + 1) begin
      check("rts_clk_we", clk_we, 0);
      check("rts_data_we", data_we, 1);
      cyc = -1;
    end
    check("ready_vs_busy", tx_ready, !busy);
    check("done_error_exclusive", done & error, 0);
    if (done) begin
      done_cnt++;
      last_done = ncyc;
    end
    if (error) err_cnt++;
    if (tx_valid && tx_ready && !reset) begin
      cyc = 0;
      last_acc = ncyc;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic offer(input logic [7:0] b);
    int g = 0;
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = b;
    while (!tx_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check("offer_ready_seen", (g < 50), 1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data  = ~b;
  endtask

  task automatic wait_rts(output bit ok);
    int g = 0;
    while (!clk_we && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    g = 0;
    while (!(!clk_we && data_we) && g < INH + 100) begin
      @(posedge clk); #1;
      g++;
    end
    ok = (g < INH + 100);
    check("rts_seen", ok, 1);
  endtask

  task automatic dev_pulse(output logic sampled);
    dev_clk_low = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    sampled = ps2_data_pin;
    dev_clk_low = 1'b0;
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  task automatic device_xfer(input bit ack, output logic [10:0] seen);
    bit ok;
    logic s;
    seen = '0;
    wait_rts(ok);
    if (!ok) return;
    repeat (30) @(posedge clk);
    #1;
    seen[0] = ps2_data_pin;
    for (int i = 1; i <= 10; i++) begin
      dev_pulse(s);
      seen[i] = s;
    end
    if (ack) dev_data_low = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    dev_pulse(s);
    dev_data_low = 1'b0;
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  task automatic run_xfer(input logic [7:0] b, input bit ack, output logic [10:0] seen);
    int dc0, ec0;
    dc0 = done_cnt;
    ec0 = err_cnt;
    offer(b);
    device_xfer(ack, seen);
    repeat (10) @(posedge clk);
    #1;
    check("frame_vs_model", seen, frame_of(b));
    check("done_pulses", done_cnt - dc0, ack ? 1 : 0);
    check("error_pulses", err_cnt - ec0, ack ? 0 : 1);
    check("ready_after_xfer", tx_ready, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [10:0] seen;
    bit ok;
    logic s;
    int k, dc0, ec0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_clk_we", clk_we, 0);
    check("rst_data_we", data_we, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // 0xED with ACK: hand-computed frame 1_1_11101101_0
    run_xfer(8'hED, 1'b1, seen);
    check("ed_frame_literal", seen, 11'b11111011010);

    // 0xF4: parity 0; frame 1_0_11110100_0
    run_xfer(8'hF4, 1'b1, seen);
    check("f4_parity_literal", seen[9], 0);
    check("f4_frame_literal", seen, 11'b10111101000);

    // 0x00 and 0xFF: parity 1
    run_xfer(8'h00, 1'b1, seen);
    check("00_parity_literal", seen[9], 1);

    // 0xFF with NACK
    run_xfer(8'hFF, 1'b0, seen);
    check("ff_parity_literal", seen[9], 1);
    check("nack_no_done", done, 0);

    // Device never clocks after RTS
    ec0 = err_cnt;
    dc0 = done_cnt;
    offer(8'h12);
    wait_rts(ok);
    k = 0;
    while (!error && k < TO + 10) begin
      @(posedge clk); #1;
      k++;
    end
    check("timeout_error_seen", error, 1);
    check("timeout_latency_window", (k >= TO && k <= TO + 2), 1);
    @(posedge clk); #1;
    check("timeout_clk_we", clk_we, 0);
    check("timeout_data_we", data_we, 0);
    check("timeout_ready", tx_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check("timeout_error_count", err_cnt - ec0, 1);
    check("timeout_no_done", done_cnt - dc0, 0);

    // Reset during SHIFT after four bits
    offer(8'hA5);
    wait_rts(ok);
    repeat (30) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) dev_pulse(s);
    check("pre_reset_busy", busy, 1);
    dc0 = done_cnt;
    ec0 = err_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_clk_we", clk_we, 0);
    check("midrst_data_we", data_we, 0);
    check("midrst_ready", tx_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_error", error, 0);
    repeat (50) @(posedge clk);
    #1;
    check("midrst_no_done_pulse", done_cnt - dc0, 0);
    check("midrst_no_error_pulse", err_cnt - ec0, 0);
    run_xfer(8'hF4, 1'b1, seen);

    // valid held across a transfer while data changes
    dc0 = done_cnt;
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    @(posedge clk); #1;
    tx_data  = 8'h55;
    device_xfer(1'b1, seen);
    check("held_first_frame", seen, frame_of(8'h3C));
    check("held_first_done", done_cnt - dc0, 1);
    check("held_accept_after_pulse", last_acc, last_done + 1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data  = 8'h99;
    device_xfer(1'b1, seen);
    repeat (10) @(posedge clk);
    #1;
    check("held_second_frame", seen, frame_of(8'h55));
    check("held_second_done", done_cnt - dc0, 2);
    check("held_idle_ready", tx_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

endmodule
